// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: program counter and instruction-fetch handshake sequencer.
// Runs each instruction as FETCH -> EXEC, picks the next PC and handles stall/halt/traps.
module pc_fetch_sequencer #(
    parameter int unsigned              INST_WIDTH   = 32,
    parameter logic [INST_WIDTH-1:0]    RESET_VECTOR = '0,
    parameter logic [INST_WIDTH-1:0]    EXC_VECTOR   = INST_WIDTH'(32'h80)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [INST_WIDTH-1:0] branch_target,
    input  logic                  jump,
    input  logic [INST_WIDTH-1:0] jump_target,
    input  logic                  exception,
    input  logic                  halt,
    input  logic                  imem_ready,
    output logic                  imem_req,
    output logic [INST_WIDTH-1:0] imem_addr,
    output logic                  inst_valid,
    output logic                  flush,
    output logic                  halted,
    output logic [INST_WIDTH-1:0] PC
);

    localparam logic [INST_WIDTH-1:0] ALIGN_MASK = ~INST_WIDTH'(3);
    localparam logic [INST_WIDTH-1:0] PC_STEP    = INST_WIDTH'(4);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [INST_WIDTH-1:0]   pc_next;
    logic                    flush_next;
    logic                    imem_req_next;
    logic                    inst_valid_next;
    logic                    halted_next;

    // The fetch address is always the current PC
    assign imem_addr = PC;

    // State, PC and registered outputs; outputs are pre-decoded from the next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= BOOT;
            PC         <= RESET_VECTOR & ALIGN_MASK;
            imem_req   <= 1'b0;
            inst_valid <= 1'b0;
            flush      <= 1'b0;
            halted     <= 1'b0;
        end else begin
            state      <= state_next;
            PC         <= pc_next;
            imem_req   <= imem_req_next;
            inst_valid <= inst_valid_next;
            flush      <= flush_next;
            halted     <= halted_next;
        end
    end

    // Next-state and next-PC selection; priority in EXEC: exception > stall > jump > branch > halt
    always_comb begin
        state_next = state;
        pc_next    = PC;
        flush_next = 1'b0;

        unique case (state)
            BOOT: begin
                state_next = FETCH;
            end
            FETCH: begin
                // Only the memory handshake matters here; all control inputs wait for EXEC
                if (imem_ready) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (exception) begin
                    pc_next    = EXC_VECTOR & ALIGN_MASK;
                    flush_next = 1'b1;
                    state_next = FETCH;
                end else if (stall) begin
                    state_next = EXEC;
                end else if (jump) begin
                    pc_next    = jump_target & ALIGN_MASK;
                    flush_next = 1'b1;
                    state_next = FETCH;
                end else if (branch_taken) begin
                    pc_next    = branch_target & ALIGN_MASK;
                    flush_next = 1'b1;
                    state_next = FETCH;
                end else if (halt) begin
                    pc_next    = PC + PC_STEP;
                    state_next = HALT;
                end else begin
                    pc_next    = PC + PC_STEP;
                    state_next = FETCH;
                end
            end
            HALT: begin
                if (exception) begin
                    pc_next    = EXC_VECTOR & ALIGN_MASK;
                    flush_next = 1'b1;
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase

        imem_req_next   = (state_next == FETCH);
        inst_valid_next = (state_next == EXEC);
        halted_next     = (state_next == HALT);
    end

endmodule
